// File: rtl/ir_pkg.sv
// Shared IR link definitions: transmit FSM states and carrier timing helpers.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } ir_tx_state_t;

  // Clocks per carrier half-period, floored.
  function automatic int unsigned ir_half_period(input int unsigned clk_hz,
                                                 input int unsigned carrier_hz);
    return clk_hz / (2 * carrier_hz);
  endfunction

  function automatic int unsigned ir_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier square wave with a half-period counter; period_tick marks the last
// cycle of each carrier period. Restarts at phase 0 (carrier high) when run rises.
module ir_carrier_gen #(
  parameter int unsigned HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic carrier,
  output logic period_tick
);

  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             car_q, car_d;
  logic             tick_q, tick_d;

  // Next phase; the tick is precomputed so it is registered alongside the carrier.
  always_comb begin
    cnt_d  = '0;
    car_d  = 1'b0;
    tick_d = 1'b0;
    if (run) begin
      if (!run_q) begin
        cnt_d = '0;
        car_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        car_d = ~car_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        car_d = car_q;
      end
      tick_d = (cnt_d == CNT_LAST) && !car_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      car_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run;
      car_q  <= car_d;
      tick_q <= tick_d;
    end
  end

  assign carrier     = car_q;
  assign period_tick = tick_q;

endmodule

// File: rtl/ir_emitter.sv
// IR transmitter: emits a frame of carrier bursts separated by silent gaps per
// start request, and flags the receiver-valid window inside each burst.
module ir_emitter
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned CARRIER_HZ    = 38_000,
  parameter int unsigned BURST_PERIODS = 10,
  parameter int unsigned GAP_PERIODS   = 10,
  parameter int unsigned BURSTS        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic start,
  output logic ir_led,
  output logic busy,
  output logic done,
  output logic echo_window
);

  localparam int unsigned HALF  = ir_half_period(CLK_HZ, CARRIER_HZ);
  localparam int unsigned PER_W = $clog2(ir_max(BURST_PERIODS, GAP_PERIODS) + 1);
  localparam int unsigned BUR_W = $clog2(BURSTS + 1);

  localparam logic [PER_W-1:0] BURST_LAST = PER_W'(BURST_PERIODS - 1);
  localparam logic [PER_W-1:0] GAP_LAST   = PER_W'(GAP_PERIODS - 1);
  localparam logic [BUR_W-1:0] FRAME_LAST = BUR_W'(BURSTS - 1);

  ir_tx_state_t     state_q, state_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [BUR_W-1:0] bur_q, bur_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             echo_q, echo_d;
  logic             run_c;
  logic             carrier;
  logic             period_tick;

  // Carrier keeps running through gaps so every burst starts on a period boundary.
  assign run_c = (state_d == BURST) || (state_d == GAP);

  ir_carrier_gen #(
    .HALF (HALF)
  ) u_carrier (
    .clk         (clk),
    .rst         (rst),
    .run         (run_c),
    .carrier     (carrier),
    .period_tick (period_tick)
  );

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    bur_d   = bur_q;
    if (!enable) begin
      state_d = IDLE;
      per_d   = '0;
      bur_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          per_d = '0;
          bur_d = '0;
          if (start) state_d = BURST;
        end
        BURST: begin
          if (period_tick) begin
            if (per_q == BURST_LAST) begin
              per_d = '0;
              if (bur_q == FRAME_LAST) begin
                state_d = DONE;
                bur_d   = '0;
              end else begin
                state_d = GAP;
                bur_d   = bur_q + BUR_W'(1);
              end
            end else begin
              per_d = per_q + PER_W'(1);
            end
          end
        end
        GAP: begin
          if (period_tick) begin
            if (per_q == GAP_LAST) begin
              state_d = BURST;
              per_d   = '0;
            end else begin
              per_d = per_q + PER_W'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          per_d   = '0;
          bur_d   = '0;
        end
        default: begin
          state_d = IDLE;
          per_d   = '0;
          bur_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    // Period 0 of each burst is receiver settle time.
    echo_d = (state_d == BURST) && (per_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      bur_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      echo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      bur_q   <= bur_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      echo_q  <= echo_d;
    end
  end

  // Both terms are flops on the same clock; the carrier is masked during gaps.
  assign ir_led      = carrier && (state_q == BURST);
  assign busy        = busy_q;
  assign done        = done_q;
  assign echo_window = echo_q;

endmodule

// File: tb/tb_ir_emitter.sv
// Directed bench for ir_emitter with a frame-position reference model.
module tb_ir_emitter;

  localparam int HALF  = 2;
  localparam int P     = 2 * HALF;
  localparam int BL    = 3 * P;
  localparam int GL    = 2 * P;
  localparam int SEG   = BL + GL;
  localparam int NB    = 2;
  localparam int FRAME = NB * BL + (NB - 1) * GL + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic ir_led, busy, done, echo_window;

  int n_chk = 0;
  int n_bad = 0;
  int frame_t = 0;

  always #5 clk = ~clk;

  ir_emitter #(
    .CLK_HZ        (400),
    .CARRIER_HZ    (100),
    .BURST_PERIODS (3),
    .GAP_PERIODS   (2),
    .BURSTS        (NB)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .enable      (enable),
    .start       (start),
    .ir_led      (ir_led),
    .busy        (busy),
    .done        (done),
    .echo_window (echo_window)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs {ir_led, busy, done, echo_window} at frame cycle t (0 = idle).
  function automatic logic [3:0] model_out(input int t);
    int s;
    if (t == 0) return 4'b0000;
    if (t == FRAME) return 4'b0110;
    s = (t - 1) % SEG;
    if (s < BL) return {((s % P) < HALF), 1'b1, 1'b0, (s >= P)};
    return 4'b0100;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_t <= 0;
    else if (!enable) frame_t <= 0;
    else if (frame_t == 0) frame_t <= start ? 1 : 0;
    else if (frame_t == FRAME) frame_t <= 0;
    else frame_t <= frame_t + 1;
  end

  always @(negedge clk) begin
    chk("cycle", 64'({ir_led, busy, done, echo_window}), 64'(model_out(frame_t)));
  end

  // Start a frame (raising enable together with start), optionally pulse
  // start again at cycles p1/p2 of the frame, and pin the full waveform.
  task automatic do_frame(input string tag, input int p1, input int p2);
    logic [32:0] led_v, echo_v, led_exp, echo_exp;
    int busy_n, done_n, done_at;
    led_v = '0; echo_v = '0; busy_n = 0; done_n = 0; done_at = 0;
    led_exp  = 33'b110011001100_00000000_110011001100_0;
    echo_exp = 33'b000011111111_00000000_000011111111_0;
    @(negedge clk);
    enable = 1'b1;
    start  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == p1) || (c == p2);
      if (c <= 33) begin
        led_v[33-c]  = ir_led;
        echo_v[33-c] = echo_window;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = c;
      end
    end
    start = 1'b0;
    chk({tag, "_led"}, 64'(led_v), 64'(led_exp));
    chk({tag, "_echo"}, 64'(echo_v), 64'(echo_exp));
    chk({tag, "_busy_len"}, 64'(busy_n), 64'd33);
    chk({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    chk({tag, "_done_at"}, 64'(done_at), 64'd33);
  endtask

  initial begin
    int act_n;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    act_n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ir_led || busy || done || echo_window) act_n++;
    end
    chk("reset_idle", 64'(act_n), 64'd0);

    do_frame("nominal", 0, 0);
    do_frame("start_busy", 3, 20);
    @(negedge clk);
    start = 1'b0;
    // Start pulsed in the DONE cycle (33) is covered by p1=33 here
    do_frame("start_done", 33, 0);
    repeat (4) @(negedge clk);
    chk("no_second_frame", 64'(busy), 64'd0);

    // Abort in gap
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 15) begin
        chk("abort_in_gap_busy", 64'(busy), 64'd1);
        chk("abort_in_gap_led", 64'(ir_led), 64'd0);
        enable = 1'b0;
      end
    end
    chk("abort_busy", 64'(busy), 64'd0);
    act_n = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) act_n++;
    end
    chk("abort_no_done", 64'(act_n), 64'd0);
    do_frame("after_abort", 0, 0);

    // Async reset mid-burst
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_led", 64'(ir_led), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_led", 64'(ir_led), 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_frame("after_reset", 0, 0);

    // Start while disabled
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    act_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ir_led || busy || done || echo_window) act_n++;
    end
    chk("disabled_start", 64'(act_n), 64'd0);
    do_frame("enable_with_start", 0, 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
